// File: rtl/mst_data_gen.sv
// mst_data_gen: streaming 16-bit incrementing test-pattern source for the
// channel-0 write path. The sequence lines up with the receive-side data
// checker, so an abandoned word is presented again and no gap appears.
// Bursts are fixed-length or continuous. The block can abort a burst and
// can corrupt one word on request so the checker's own error path can be
// exercised.
module mst_data_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] burst_len_i,
  input  logic             seq_clr_i,
  input  logic             erinj_i,
  input  logic             tx_rdy_i,
  output logic             ch0_vld_o,
  output logic [15:0]      wdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic             ch0Vld_q;
  logic             busy_q;
  logic             done_q;

  logic [15:0]      pat_q, pat_d;
  logic [CNT_W-1:0] wordCnt_q, wordCnt_d;
  logic [CNT_W-1:0] burstLen_q, burstLen_d;
  logic [CNT_W-1:0] wordCntInc;
  logic             injPend_q, injPend_d;
  logic             injAct_q, injAct_d;

  logic             accept;
  logic             xfer;
  logic             lastWord;
  logic             finish;
  logic             loadWord;

  // Burst control events. A word is loaded onto the bus on RUN entry or
  // after a transfer that does not end the burst.
  always_comb begin
    accept     = (state_q == IDLE) && start_i;
    xfer       = (state_q == RUN) && tx_rdy_i;
    wordCntInc = wordCnt_q + CNT_W'(1);
    lastWord   = xfer && (burstLen_q != '0) && (wordCntInc == burstLen_q);
    finish     = (state_q == RUN) && (stop_i || lastWord);
    loadWord   = accept || (xfer && !finish);
  end

  // The pattern advances only on a transfer. It can be cleared only while
  // IDLE, so a stalled word that is abandoned is presented again next burst.
  always_comb begin
    pat_d = pat_q;
    if ((state_q == IDLE) && seq_clr_i) begin
      pat_d = 16'h0000;
    end
    if (xfer) begin
      pat_d = pat_q + 16'h0001;
    end
  end

  // The word counter restarts on an accepted start and counts only completed
  // transfers. It holds after the burst so the last count stays visible.
  always_comb begin
    wordCnt_d  = wordCnt_q;
    burstLen_d = burstLen_q;
    if (accept) begin
      wordCnt_d  = '0;
      burstLen_d = burst_len_i;
    end else if (xfer) begin
      wordCnt_d = wordCntInc;
    end
  end

  // Pending injection is consumed only when a fresh word is loaded. Because
  // of this, a stalled word never changes. An erinj in the same cycle stays
  // pending for a later word.
  always_comb begin
    injAct_d  = injAct_q;
    injPend_d = injPend_q | erinj_i;
    if (xfer || finish) begin
      injAct_d = 1'b0;
    end
    if (loadWord && injPend_q) begin
      injAct_d  = 1'b1;
      injPend_d = erinj_i;
    end
  end

  // Burst FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch0Vld_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q  <= RUN;
            ch0Vld_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (finish) begin
            state_q  <= DONE;
            ch0Vld_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          ch0Vld_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers: pattern, counters, latched length, injection flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q      <= 16'h0000;
      wordCnt_q  <= '0;
      burstLen_q <= '0;
      injPend_q  <= 1'b0;
      injAct_q   <= 1'b0;
    end else begin
      pat_q      <= pat_d;
      wordCnt_q  <= wordCnt_d;
      burstLen_q <= burstLen_d;
      injPend_q  <= injPend_d;
      injAct_q   <= injAct_d;
    end
  end

  assign ch0_vld_o  = ch0Vld_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign word_cnt_o = wordCnt_q;
  assign wdata_o    = pat_q ^ {15'b0, injAct_q};

endmodule

// File: tb/tb_mst_data_gen.sv
// tb_mst_data_gen: directed bench for mst_data_gen with a cycle model and
// hand-computed expectations for each scenario.
module tb_mst_data_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, seqClr, erinj, txRdy;
  logic [15:0] burstLen;
  logic        ch0Vld, busy, done;
  logic [15:0] wdata;
  logic [15:0] wordCnt;

  int checks = 0;
  int passes = 0;

  // Model of the generator's observable behaviour.
  logic        mRun  = 1'b0;
  logic        mEnd  = 1'b0;
  logic [15:0] mPat  = 16'h0;
  logic [15:0] mCnt  = 16'h0;
  logic [15:0] mLen  = 16'h0;
  logic        mPend = 1'b0;
  logic        mBad  = 1'b0;

  mst_data_gen #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .stop_i     (stop),
    .burst_len_i(burstLen),
    .seq_clr_i  (seqClr),
    .erinj_i    (erinj),
    .tx_rdy_i   (txRdy),
    .ch0_vld_o  (ch0Vld),
    .wdata_o    (wdata),
    .busy_o     (busy),
    .done_o     (done),
    .word_cnt_o (wordCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic sc,
                               input logic ei, input logic rdy, input logic [15:0] len);
    start    = st;
    stop     = sp;
    seqClr   = sc;
    erinj    = ei;
    txRdy    = rdy;
    burstLen = len;
    @(negedge clk);
  endtask

  task automatic waitIdle(input int maxCycles, input logic [15:0] len);
    for (int i = 0; i < maxCycles && busy; i++) applyStimulus(0, 0, 0, 0, 1, len);
    checkOutput("waitIdle busy", 32'(busy), 32'd0);
  endtask

  // Model step: one clock of the generator's rules, written as word/burst
  // bookkeeping rather than a state machine.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mRun <= 1'b0; mEnd <= 1'b0; mPat <= 16'h0; mCnt <= 16'h0;
      mLen <= 16'h0; mPend <= 1'b0; mBad <= 1'b0;
    end else begin : step
      logic r, e, pd, bd, fire, load, fin;
      logic [15:0] p, c, l;
      r = mRun; e = mEnd; pd = mPend; bd = mBad; p = mPat; c = mCnt; l = mLen;
      fire = r && txRdy;
      load = 1'b0;
      fin  = 1'b0;
      if (e) begin
        e = 1'b0;
      end else if (!r) begin
        if (seqClr) p = 16'h0;
        if (start) begin
          r = 1'b1; l = burstLen; c = 16'h0; load = 1'b1;
        end
      end else begin
        if (fire) begin
          p = p + 16'd1; c = c + 16'd1; bd = 1'b0;
        end
        fin = stop || (fire && l != 16'h0 && c == l);
        if (fin) begin
          r = 1'b0; e = 1'b1; bd = 1'b0;
        end else if (fire) begin
          load = 1'b1;
        end
      end
      if (load && pd) begin
        bd = 1'b1; pd = erinj;
      end else if (erinj) begin
        pd = 1'b1;
      end
      mRun <= r; mEnd <= e; mPend <= pd; mBad <= bd; mPat <= p; mCnt <= c; mLen <= l;
    end
  end

  // Compare every output against the model on each falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("model ch0_vld", 32'(ch0Vld), 32'(mRun));
      checkOutput("model busy", 32'(busy), 32'(mRun | mEnd));
      checkOutput("model done", 32'(done), 32'(mEnd));
      checkOutput("model wdata", 32'(wdata), 32'(mPat ^ {15'b0, mBad}));
      checkOutput("model word_cnt", 32'(wordCnt), 32'(mCnt));
    end
  end

  // Watchdog so the bench always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with literal expectations.
  initial begin
    rst_n = 1'b0;
    start = 0; stop = 0; seqClr = 0; erinj = 0; txRdy = 0; burstLen = 16'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset ch0_vld", 32'(ch0Vld), 32'd0);
    checkOutput("reset wdata", 32'(wdata), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset word_cnt", 32'(wordCnt), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic burst");
    applyStimulus(1, 0, 0, 0, 1, 4);
    checkOutput("basic vld", 32'(ch0Vld), 32'd1);
    checkOutput("basic w0", 32'(wdata), 32'h0000);
    applyStimulus(0, 0, 0, 0, 1, 4);
    checkOutput("basic w1", 32'(wdata), 32'h0001);
    applyStimulus(0, 0, 0, 0, 1, 4);
    checkOutput("basic w2", 32'(wdata), 32'h0002);
    applyStimulus(0, 0, 0, 0, 1, 4);
    checkOutput("basic w3", 32'(wdata), 32'h0003);
    applyStimulus(0, 0, 0, 0, 1, 4);
    checkOutput("basic done", 32'(done), 32'd1);
    checkOutput("basic vld off", 32'(ch0Vld), 32'd0);
    checkOutput("basic word_cnt", 32'(wordCnt), 32'd4);
    applyStimulus(0, 0, 0, 0, 1, 4);
    checkOutput("basic busy low", 32'(busy), 32'd0);
    checkOutput("basic done low", 32'(done), 32'd0);
    applyStimulus(1, 0, 0, 0, 1, 4);
    checkOutput("basic second w0", 32'(wdata), 32'h0004);
    waitIdle(20, 4);

    $display("[TB] backpressure");
    applyStimulus(1, 0, 1, 0, 1, 16);
    checkOutput("bp w0", 32'(wdata), 32'h0000);
    for (int i = 0; i < 400 && busy; i++) applyStimulus(0, 0, 0, 0, 1'($urandom_range(0, 1)), 16);
    checkOutput("bp busy", 32'(busy), 32'd0);
    checkOutput("bp word_cnt", 32'(wordCnt), 32'd16);

    $display("[TB] abort while stalled");
    applyStimulus(1, 0, 1, 0, 1, 0);
    checkOutput("abort w0", 32'(wdata), 32'h0000);
    repeat (7) applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("abort w7", 32'(wdata), 32'h0007);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("abort stalled w7", 32'(wdata), 32'h0007);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("abort done", 32'(done), 32'd1);
    checkOutput("abort vld", 32'(ch0Vld), 32'd0);
    checkOutput("abort word_cnt", 32'(wordCnt), 32'd7);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("abort idle", 32'(busy), 32'd0);
    applyStimulus(1, 0, 0, 0, 1, 2);
    checkOutput("abort resume w7", 32'(wdata), 32'h0007);
    waitIdle(20, 2);
    applyStimulus(0, 0, 1, 0, 1, 2);
    applyStimulus(1, 0, 0, 0, 1, 2);
    checkOutput("seq_clr w0", 32'(wdata), 32'h0000);
    waitIdle(20, 2);

    $display("[TB] error injection");
    applyStimulus(1, 0, 1, 0, 1, 8);
    checkOutput("inj w0", 32'(wdata), 32'h0000);
    repeat (4) applyStimulus(0, 0, 0, 0, 1, 8);
    checkOutput("inj w4", 32'(wdata), 32'h0004);
    applyStimulus(0, 0, 0, 1, 0, 8);
    checkOutput("inj stalled w4 a", 32'(wdata), 32'h0004);
    applyStimulus(0, 0, 0, 1, 0, 8);
    checkOutput("inj stalled w4 b", 32'(wdata), 32'h0004);
    applyStimulus(0, 0, 0, 0, 1, 8);
    checkOutput("inj corrupted w5", 32'(wdata), 32'h0004);
    applyStimulus(0, 0, 0, 0, 1, 8);
    checkOutput("inj clean w6", 32'(wdata), 32'h0006);
    waitIdle(20, 8);
    checkOutput("inj word_cnt", 32'(wordCnt), 32'd8);

    $display("[TB] continuous wrap");
    applyStimulus(1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 65536; i++) applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("wrap wdata", 32'(wdata), 32'h0000);
    checkOutput("wrap word_cnt", 32'(wordCnt), 32'd0);
    repeat (2) applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("wrap w2", 32'(wdata), 32'h0002);
    applyStimulus(0, 1, 0, 0, 1, 0);
    checkOutput("wrap stop done", 32'(done), 32'd1);
    checkOutput("wrap stop word_cnt", 32'(wordCnt), 32'd3);
    applyStimulus(0, 0, 0, 0, 1, 0);

    $display("[TB] reset mid-burst");
    applyStimulus(1, 0, 0, 0, 1, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("rst pre busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst vld", 32'(ch0Vld), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst wdata", 32'(wdata), 32'h0);
    checkOutput("rst word_cnt", 32'(wordCnt), 32'd0);
    @(negedge clk);
    checkOutput("rst no done", 32'(done), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1, 1, 0, 0, 1, 3);
    checkOutput("start wins vld", 32'(ch0Vld), 32'd1);
    checkOutput("after rst w0", 32'(wdata), 32'h0000);
    applyStimulus(0, 0, 0, 0, 1, 3);
    checkOutput("after rst w1", 32'(wdata), 32'h0001);
    waitIdle(20, 3);
    checkOutput("after rst word_cnt", 32'(wordCnt), 32'd3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
